// File: rtl/uart_tx_core.sv
// UART transmitter: sends start, DATA_WIDTH data bits LSB first, optional parity, stop.
// One bit per CLK cycle; TX_OUT and busy come straight from flops.
module uart_tx_core #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int unsigned      CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] data_q, data_n;
  logic [CNT_W-1:0]      bit_cnt, bit_cnt_n;
  logic                  par_en_q, par_en_n;
  logic                  par_bit_q, par_bit_n;
  logic                  tx_n, busy_n;

  // State, frame registers and registered line outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= S_IDLE;
      data_q    <= '0;
      bit_cnt   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      TX_OUT    <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      data_q    <= data_n;
      bit_cnt   <= bit_cnt_n;
      par_en_q  <= par_en_n;
      par_bit_q <= par_bit_n;
      TX_OUT    <= tx_n;
      busy      <= busy_n;
    end
  end

  // Next state; tx_n is the line level for the state being entered
  always_comb begin
    state_n   = state;
    data_n    = data_q;
    bit_cnt_n = bit_cnt;
    par_en_n  = par_en_q;
    par_bit_n = par_bit_q;
    tx_n      = TX_OUT;
    busy_n    = busy;

    case (state)
      S_IDLE: begin
        if (Data_Valid) begin
          data_n    = P_DATA;
          par_en_n  = PAR_EN;
          par_bit_n = PAR_TYP ? ~^P_DATA : ^P_DATA;
          bit_cnt_n = '0;
          state_n   = S_START;
          tx_n      = 1'b0;
          busy_n    = 1'b1;
        end
      end
      S_START: begin
        state_n   = S_DATA;
        bit_cnt_n = '0;
        tx_n      = data_q[0];
      end
      S_DATA: begin
        if (bit_cnt == LAST_BIT) begin
          bit_cnt_n = '0;
          if (par_en_q) begin
            state_n = S_PARITY;
            tx_n    = par_bit_q;
          end else begin
            state_n = S_STOP;
            tx_n    = 1'b1;
          end
        end else begin
          bit_cnt_n = bit_cnt + CNT_W'(1);
          tx_n      = data_q[bit_cnt_n];
        end
      end
      S_PARITY: begin
        state_n = S_STOP;
        tx_n    = 1'b1;
      end
      S_STOP: begin
        state_n = S_IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
      default: begin
        state_n   = S_IDLE;
        bit_cnt_n = '0;
        tx_n      = 1'b1;
        busy_n    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Scoreboard bench for uart_tx_core: a frame model queues the expected {TX_OUT,busy}
// per cycle on each accept; a negedge monitor pops and compares every cycle.
module tb_uart_tx_core;

  localparam int unsigned DW = 8;

  logic          CLK;
  logic          RST;
  logic [DW-1:0] P_DATA;
  logic          Data_Valid;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic          TX_OUT;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  logic [1:0] exp_q[$];
  int         rem     = 0;
  int         acc_cnt = 0;
  int         cyc     = 0;
  int         rise_q[$];
  logic       prev_busy = 1'b0;
  logic       mon_en    = 1'b0;

  uart_tx_core #(.DATA_WIDTH(DW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .busy       (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // Frame model: queue one {line, busy} pair per frame cycle at the accept edge
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      exp_q.delete();
      rem = 0;
    end else if (rem == 0 && Data_Valid) begin
      exp_q.push_back(2'b01);
      for (int i = 0; i < DW; i++) exp_q.push_back({P_DATA[i], 1'b1});
      if (PAR_EN) exp_q.push_back({(PAR_TYP ? ~^P_DATA : ^P_DATA), 1'b1});
      exp_q.push_back(2'b11);
      rem = PAR_EN ? DW + 3 : DW + 2;
      acc_cnt++;
    end else if (rem != 0) begin
      rem--;
    end
  end

  // Monitor: idle line {1,0} expected whenever nothing is queued
  always @(negedge CLK) begin
    logic [1:0] e;
    cyc++;
    if (mon_en) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'b10;
      check("line_tx_busy", 32'({TX_OUT, busy}), 32'(e));
      if (busy && !prev_busy) rise_q.push_back(cyc);
      prev_busy = busy;
    end
  end

  task automatic scramble_inputs();
    P_DATA  = DW'($urandom);
    PAR_EN  = 1'($urandom);
    PAR_TYP = 1'($urandom);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge CLK);
      done = (exp_q.size() == 0 && rem == 0);
    end
    if (!done) check("wait_idle_timeout", 32'(1), 32'(0));
    repeat (2) @(negedge CLK);
  endtask

  task automatic wait_accepts(input int target);
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge CLK);
      done = (acc_cnt >= target);
    end
    if (!done) check("accept_timeout", 32'(acc_cnt), 32'(target));
  endtask

  // One-cycle request, then inputs change to prove they were latched
  task automatic send(input logic [DW-1:0] d, input logic pe, input logic pt);
    @(negedge CLK);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    scramble_inputs();
  endtask

  initial begin
    RST        = 1'b1;
    P_DATA     = '0;
    Data_Valid = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    #1 RST = 1'b0;
    #1 mon_en = 1'b1;
    check("reset_tx", 32'(TX_OUT), 32'(1));
    check("reset_busy", 32'(busy), 32'(0));
    repeat (3) @(negedge CLK);
    RST = 1'b1;

    repeat (20) @(negedge CLK);

    send(8'hA5, 1'b0, 1'b0);
    wait_idle();
    send(8'h07, 1'b1, 1'b0);
    wait_idle();
    send(8'h07, 1'b1, 1'b1);
    wait_idle();
    send(8'h80, 1'b1, 1'b1);
    wait_idle();

    // Data_Valid held high across two frames
    begin
      int base;
      base = acc_cnt;
      @(negedge CLK);
      P_DATA     = 8'h55;
      PAR_EN     = 1'b0;
      Data_Valid = 1'b1;
      wait_accepts(base + 1);
      P_DATA = 8'hAA;
      wait_accepts(base + 2);
      @(negedge CLK);
      Data_Valid = 1'b0;
      wait_idle();
      check("acc_count_held", 32'(acc_cnt), 32'(base + 2));
      if (rise_q.size() >= 2)
        check("b2b_period", 32'(rise_q[rise_q.size()-1] - rise_q[rise_q.size()-2]), 32'(11));
      else
        check("b2b_rises", 32'(rise_q.size()), 32'(2));
    end

    // Request during DATA of a 0x00 frame is dropped
    send(8'h00, 1'b0, 1'b0);
    repeat (3) @(negedge CLK);
    P_DATA     = 8'hFF;
    Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    wait_idle();

    // Reset during data bit 4 aborts the frame
    @(negedge CLK);
    P_DATA     = 8'h96;
    PAR_EN     = 1'b0;
    Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    repeat (5) @(negedge CLK);
    check("pre_rst_busy", 32'(busy), 32'(1));
    #2 RST = 1'b0;
    #1;
    check("rst_async_tx", 32'(TX_OUT), 32'(1));
    check("rst_async_busy", 32'(busy), 32'(0));
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    send(8'h3C, 1'b1, 1'b0);
    wait_idle();
    send(8'h3C, 1'b0, 1'b0);
    wait_idle();

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
